rced_sc_et: RTL and testbench
=============================

RCED_SC_ET -- requirements
Module: rced_sc_et

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the pixel precision in bits; the stream length is L = 2^WIDTH-1; supported range 4..16.
REQ-002 Parameter THRESH, default 32, SHALL set the edge-decision threshold on the ones count; legal range 1..L.
REQ-003 Parameter SEED_X, default 1, SHALL seed the pixel LFSR; SEED_C, default 2^(WIDTH-1)+1, SHALL seed the select LFSR; both must be nonzero.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  request a new window; accepted only while ready=1.
REQ-007 px  input  4 x WIDTH  window pixels px[0..3], sampled at acceptance.
REQ-008 ready  output  1  idle, start accepted.
REQ-009 done  output  1  one-cycle pulse, result valid.
REQ-010 count  output  WIDTH  ones count of the output stream; held until next acceptance.
REQ-011 edge  output  1  edge decision (count >= THRESH); held with count.
REQ-012 cycles  output  WIDTH  stream bits consumed for this result; held with count.

Function
REQ-013 FSM states IDLE, RUN, DONE; IDLE->RUN on start&ready; RUN->DONE on termination; DONE->IDLE unconditionally next cycle.
REQ-014 ready SHALL be 1 only in IDLE; start in RUN/DONE SHALL be ignored, px unlatched.
REQ-015 On acceptance, px SHALL latch, both LFSRs SHALL load their seeds, and the ones counter and cycle counter SHALL clear.
REQ-016 Each RUN cycle, with pixel LFSR value r (1..L): x_i = (r <= px_i), so px_i ones over the full period.
REQ-017 Select bit c SHALL be the MSB of the select LFSR; z = c ? (x0 ^ x3) : (x1 ^ x2).
REQ-018 Each RUN cycle SHALL add z to the ones counter, increment the cycle counter, and step both LFSRs.
REQ-019 Full-length termination: after exactly L RUN cycles.
REQ-020 done SHALL assert in the DONE cycle; count/edge/cycles SHALL update on the same edge and be stable from then on.
REQ-021 Latency, no early termination: start sampled at edge 0, done high in the cycle after edge L+1.
REQ-022 The counters cannot overflow: both saturate naturally at L within WIDTH bits.

Reset
REQ-023 With rst_n low, state=IDLE, ready=1, done=0, count=0, edge=0, cycles=0, LFSRs=seeds, asynchronously.
REQ-024 Reset during RUN SHALL abort the window without a done pulse; the next start SHALL behave as from power-up.

Configuration
REQ-025 Macro RCED_SC_EARLY_TERM_EN defined: RUN SHALL also terminate on the first cycle where ones >= THRESH (edge=1) or ones + (L - cycles) < THRESH (edge=0), counts evaluated after that cycle's update.
REQ-026 Macro undefined: every window runs exactly L cycles; edge computed from the final count only.
REQ-027 Edge SHALL be identical with and without the macro for the same inputs.

Structure
REQ-028 Package rced_sc_pkg SHALL hold the FSM state enum and a maximal-length tap-mask constant table indexed by WIDTH (4..16).
REQ-029 A sub-module sc_lfsr (parameters WIDTH, SEED; ports clk, rst_n, load, en, q) SHALL be instantiated twice.

Verification
REQ-030 WIDTH=8, THRESH=32, px all 100 -> z always 0; full: count=0, cycles=255, edge=0; ET: done at cycles=224, count=0, edge=0.
REQ-031 px={255,0,0,0} -> z=c; full: count=128, cycles=255, edge=1; ET: count=32, edge=1, cycles<255.
REQ-032 px={200,50,120,120} full run -> count equals a software model of REQ-016/017 using the same taps and seeds, bit-exact.
REQ-033 start pulsed during RUN with different px -> ignored; result matches the first window; exactly one done pulse.
REQ-034 rst_n low at RUN cycle 100 -> no done; outputs 0, ready=1; the next window matches the power-up result.
REQ-035 Back-to-back: start held high -> a new window is accepted the cycle after each DONE; each done pulse is one cycle wide.

Source files
------------

// File: rtl/rced_sc_pkg.sv
// rtl/rced_sc_pkg.sv - shared FSM state type and maximal-length LFSR tap table
package rced_sc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Fibonacci feedback masks: bit n-1 set for tap n, index = register width
    localparam logic [15:0] LFSR_TAPS [4:16] = '{
        16'h000C,   // 4:  4,3
        16'h0014,   // 5:  5,3
        16'h0030,   // 6:  6,5
        16'h0060,   // 7:  7,6
        16'h00B8,   // 8:  8,6,5,4
        16'h0110,   // 9:  9,5
        16'h0240,   // 10: 10,7
        16'h0500,   // 11: 11,9
        16'h0829,   // 12: 12,6,4,1
        16'h100D,   // 13: 13,4,3,1
        16'h2015,   // 14: 14,5,3,1
        16'h6000,   // 15: 15,14
        16'hD008    // 16: 16,15,13,4
    };

endpackage

// File: rtl/sc_lfsr.sv
// rtl/sc_lfsr.sv - maximal-length Fibonacci LFSR with seed load and step enable
module sc_lfsr
    import rced_sc_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    localparam logic [15:0]      TAPS_FULL = LFSR_TAPS[WIDTH];
    localparam logic [WIDTH-1:0] TAPS      = TAPS_FULL[WIDTH-1:0];

    logic [WIDTH-1:0] r_q;
    logic             w_fb;

    assign w_fb = ^(r_q & TAPS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= SEED;
        end else if (load) begin
            r_q <= SEED;
        end else if (en) begin
            r_q <= {r_q[WIDTH-2:0], w_fb};
        end
    end

    assign q = r_q;

endmodule

// File: rtl/rced_sc_et.sv
// rtl/rced_sc_et.sv - stochastic Roberts-cross edge detector; RCED_SC_EARLY_TERM_EN enables early termination
module rced_sc_et
    import rced_sc_pkg::*;
#(
    parameter int               WIDTH  = 8,
    parameter int               THRESH = 32,
    parameter logic [WIDTH-1:0] SEED_X = WIDTH'(1),
    parameter logic [WIDTH-1:0] SEED_C = WIDTH'((1 << (WIDTH-1)) + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [3:0][WIDTH-1:0] i_px,
    output logic                  o_ready,
    output logic                  o_done,
    output logic [WIDTH-1:0]      o_count,
    output logic                  o_edge,
    output logic [WIDTH-1:0]      o_cycles
);

    localparam logic [WIDTH-1:0] L   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] THR = WIDTH'(THRESH);

    state_t                r_state;
    state_t                w_next;
    logic [3:0][WIDTH-1:0] r_px;
    logic [WIDTH-1:0]      r_ones;
    logic [WIDTH-1:0]      r_cyc;
    logic [WIDTH-1:0]      r_count;
    logic                  r_edge;
    logic [WIDTH-1:0]      r_cycles;
    logic [WIDTH-1:0]      w_rx;
    logic [WIDTH-1:0]      w_rc;
    logic [3:0]            w_x;
    logic                  w_z;
    logic                  w_accept;
    logic                  w_term;
    logic                  w_step;

    assign w_accept = (r_state == ST_IDLE) && i_start;

    // Termination is judged on the registered counts, so a full window spends one
    // extra RUN cycle after its L-th update before moving to DONE.
`ifdef RCED_SC_EARLY_TERM_EN
    logic [WIDTH:0] w_reach;
    assign w_reach = {1'b0, r_ones} + {1'b0, L - r_cyc};
    assign w_term  = (r_cyc == L) || (r_ones >= THR) || (w_reach < {1'b0, THR});
`else
    assign w_term  = (r_cyc == L);
`endif

    assign w_step = (r_state == ST_RUN) && !w_term;

    sc_lfsr #(.WIDTH(WIDTH), .SEED(SEED_X)) u_lfsr_x (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_accept),
        .en    (w_step),
        .q     (w_rx)
    );

    sc_lfsr #(.WIDTH(WIDTH), .SEED(SEED_C)) u_lfsr_c (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_accept),
        .en    (w_step),
        .q     (w_rc)
    );

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_x[i] = (w_rx <= r_px[i]);
        end
    end

    assign w_z = w_rc[WIDTH-1] ? (w_x[0] ^ w_x[3]) : (w_x[1] ^ w_x[2]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (i_start) w_next = ST_RUN;
            ST_RUN:  if (w_term)  w_next = ST_DONE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_px     <= '0;
            r_ones   <= '0;
            r_cyc    <= '0;
            r_count  <= '0;
            r_edge   <= 1'b0;
            r_cycles <= '0;
        end else begin
            if (w_accept) begin
                r_px   <= i_px;
                r_ones <= '0;
                r_cyc  <= '0;
            end else if (w_step) begin
                r_ones <= r_ones + {{(WIDTH-1){1'b0}}, w_z};
                r_cyc  <= r_cyc + 1'b1;
            end
            if ((r_state == ST_RUN) && w_term) begin
                r_count  <= r_ones;
                r_edge   <= (r_ones >= THR);
                r_cycles <= r_cyc;
            end
        end
    end

    assign o_ready  = (r_state == ST_IDLE);
    assign o_done   = (r_state == ST_DONE);
    assign o_count  = r_count;
    assign o_edge   = r_edge;
    assign o_cycles = r_cycles;

endmodule

// File: tb/tb_rced_sc_et.sv
// tb/tb_rced_sc_et.sv - scoreboard bench for rced_sc_et (WIDTH=8, THRESH=32)
module tb_rced_sc_et;

    typedef struct packed {
        logic [7:0] count;
        logic [7:0] cycles;
        logic       edg;
    } res_t;

`ifdef RCED_SC_EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif

    logic            clk;
    logic            rst_n;
    logic            i_start;
    logic [3:0][7:0] i_px;
    logic            o_ready;
    logic            o_done;
    logic [7:0]      o_count;
    logic            o_edge;
    logic [7:0]      o_cycles;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_done  = 0;
    int   cyc_ctr = 0;
    int   last_done_cyc = 0;
    logic prev_done = 1'b0;
    res_t exp_q[$];

    rced_sc_et #(.WIDTH(8), .THRESH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (i_start),
        .i_px     (i_px),
        .o_ready  (o_ready),
        .o_done   (o_done),
        .o_count  (o_count),
        .o_edge   (o_edge),
        .o_cycles (o_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input logic [7:0] p0, input logic [7:0] p1,
                                   input logic [7:0] p2, input logic [7:0] p3);
        logic [7:0] rx, rc, ones, cyc;
        logic       x0, x1, x2, x3, z;
        res_t       r;
        rx = 8'd1; rc = 8'h81; ones = 8'd0; cyc = 8'd0;
        for (int k = 0; k < 255; k++) begin
            if (ET && ((ones >= 8'd32) || (int'(ones) + 255 - int'(cyc) < 32))) break;
            x0 = (rx <= p0); x1 = (rx <= p1); x2 = (rx <= p2); x3 = (rx <= p3);
            z  = rc[7] ? (x0 ^ x3) : (x1 ^ x2);
            ones = ones + {7'd0, z};
            cyc  = cyc + 8'd1;
            rx = {rx[6:0], ^(rx & 8'hB8)};
            rc = {rc[6:0], ^(rc & 8'hB8)};
        end
        r.count  = ones;
        r.cycles = cyc;
        r.edg    = (ones >= 8'd32);
        return r;
    endfunction

    always @(negedge clk) begin
        res_t e;
        if (rst_n && o_done) begin
            n_done++;
            check("done_width", {31'd0, prev_done}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("count",  {24'd0, o_count},  {24'd0, e.count});
                check("cycles", {24'd0, o_cycles}, {24'd0, e.cycles});
                check("edge",   {31'd0, o_edge},   {31'd0, e.edg});
            end
            last_done_cyc = cyc_ctr;
        end
        prev_done = o_done;
        cyc_ctr++;
    end

    task automatic start_window(input logic [7:0] p0, input logic [7:0] p1,
                                input logic [7:0] p2, input logic [7:0] p3, input res_t e);
        int guard = 0;
        @(negedge clk);
        while (!o_ready && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (!o_ready) check("ready_timeout", 32'd0, 32'd1);
        i_px[0] = p0; i_px[1] = p1; i_px[2] = p2; i_px[3] = p3;
        i_start = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done(output int t);
        int target = n_done + 1;
        int guard  = 0;
        while (n_done < target && guard < 2000) begin
            @(negedge clk); #1;
            guard++;
        end
        if (n_done < target) check("done_timeout", n_done, target);
        t = last_done_cyc;
    endtask

    initial begin
        res_t e;
        res_t e_b;
        int   t0, t1, t2, nd;

        rst_n = 1'b0; i_start = 1'b0; i_px = '0;
        repeat (3) @(negedge clk);
        check("rst_ready",  {31'd0, o_ready}, 32'd1);
        check("rst_done",   {31'd0, o_done},  32'd0);
        check("rst_count",  {24'd0, o_count}, 32'd0);
        check("rst_edge",   {31'd0, o_edge},  32'd0);
        check("rst_cycles", {24'd0, o_cycles}, 32'd0);
        rst_n = 1'b1;

        // equal pixels: x0..x3 always equal, so z is always 0
        e.count = 8'd0; e.cycles = ET ? 8'd224 : 8'd255; e.edg = 1'b0;
        start_window(8'd100, 8'd100, 8'd100, 8'd100, e);
        wait_done(t0);

        // only px0 saturated: z equals the select bit
        e = model(8'd255, 8'd0, 8'd0, 8'd0);
        if (!ET) begin
            e.count = 8'd128; e.cycles = 8'd255; e.edg = 1'b1;
        end
        check("px255_model_count", {24'd0, e.count}, ET ? 32'd32 : 32'd128);
        start_window(8'd255, 8'd0, 8'd0, 8'd0, e);
        wait_done(t0);

        e_b = model(8'd200, 8'd50, 8'd120, 8'd120);
        start_window(8'd200, 8'd50, 8'd120, 8'd120, e_b);
        wait_done(t0);

        // start during RUN with other pixels is ignored
        start_window(8'd200, 8'd50, 8'd120, 8'd120, e_b);
        repeat (20) @(negedge clk);
        i_px[0] = 8'd7; i_px[1] = 8'd9; i_px[2] = 8'd250; i_px[3] = 8'd3;
        check("busy_ready", {31'd0, o_ready}, 32'd0);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        nd = n_done;
        wait_done(t0);
        repeat (300) @(negedge clk);
        check("single_done", n_done, nd + 1);

        // reset mid-window aborts it
        start_window(8'd255, 8'd0, 8'd0, 8'd0, e);
        repeat (100) @(negedge clk);
        nd = n_done;
        #1 rst_n = 1'b0;
        #1;
        check("abort_ready",  {31'd0, o_ready}, 32'd1);
        check("abort_done",   {31'd0, o_done},  32'd0);
        check("abort_count",  {24'd0, o_count}, 32'd0);
        check("abort_edge",   {31'd0, o_edge},  32'd0);
        check("abort_cycles", {24'd0, o_cycles}, 32'd0);
        void'(exp_q.pop_back());
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        check("abort_no_done", n_done, nd);
        start_window(8'd200, 8'd50, 8'd120, 8'd120, e_b);
        wait_done(t0);

        // start held high: windows run back to back
        exp_q.push_back(e);
        exp_q.push_back(e);
        @(negedge clk);
        i_px[0] = 8'd255; i_px[1] = 8'd0; i_px[2] = 8'd0; i_px[3] = 8'd0;
        exp_q.push_back(e);
        i_start = 1'b1;
        wait_done(t0);
        wait_done(t1);
        wait_done(t2);
        i_start = 1'b0;
        check("b2b_gap1", t1 - t0, int'(e.cycles) + 3);
        check("b2b_gap2", t2 - t1, int'(e.cycles) + 3);
        repeat (300) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
